buff_ip_to_nn: RTL and testbench
================================

Name: buff_ip_to_nn

Overview:
- Bridge between the UDP/IP receive path and the neural-net input buffer.
- On FRAME_READY, latches one complete user-data frame (784 pixel bytes) plus the sender's MAC/IP/UDP addressing.
- Then streams the frame one pixel per clock as row/column-addressed 18-bit fixed-point writes into the NN image memory.
- Pulses W_DONE when the full image has been written.

Parameters:
- USER_DATA_BYTES, 784, number of pixel bytes per frame (28x28 image).
- IMG_COLS, 28, pixels per image row; used for row/col generation.
- IP_ADDR_WIDTH, 32, IPv4 address width.
- MAC_ADDR_WIDTH, 48, MAC address width.
- UDP_PORT_WIDTH, 16, UDP port width.

Ports:
- ACLK  in  1  clock; all logic on rising edge.
- ARESET  in  1  reset; asynchronous, active-high.
- DATA_FRAME_IP  in  [0:USER_DATA_BYTES*8-1]  frame payload; byte i occupies bits [i*8 +: 8], with byte 0 leftmost and big-endian ascending.
- SRC_IP_ADDRESS_IP  in  [0:IP_ADDR_WIDTH-1]  sender IP from the IP stack.
- SRC_MAC_ADDRESS_IP  in  [0:MAC_ADDR_WIDTH-1]  sender MAC.
- SRC_UDP_PORT_IP  in  [0:UDP_PORT_WIDTH-1]  sender UDP port.
- FRAME_READY  in  1  one-cycle strobe: frame and addresses valid.
- SRC_IP_ADDRESS_NN  out  [0:IP_ADDR_WIDTH-1]  latched sender IP to NN.
- SRC_MAC_ADDRESS_NN  out  [0:MAC_ADDR_WIDTH-1]  latched sender MAC.
- SRC_UDP_PORT_NN  out  [0:UDP_PORT_WIDTH-1]  latched sender port.
- W_DATA  out  18 signed  pixel value.
- W_EN  out  1  write enable for the NN image memory.
- W_ROW  out  5  pixel row (0..27).
- W_COL  out  5  pixel column (0..27).
- W_DONE  out  1  image-complete pulse.

Behaviour:
- Reset (async, ARESET=1):
  - State goes to IDLE.
  - Frame buffer, address outputs, W_DATA, W_ROW, W_COL and index are cleared to 0.
  - W_EN=0, W_DONE=0.
- States: IDLE, STREAM.
- IDLE:
  - W_EN=0, W_ROW=0, W_COL=0.
  - On a rising edge with FRAME_READY=1, latch DATA_FRAME_IP into an internal buffer, latch all three SRC_*_IP inputs to the SRC_*_NN outputs, clear the index to 0, and go to STREAM.
- STREAM:
  - Starting on the edge after the capture edge, one pixel is presented per cycle: element i=0..USER_DATA_BYTES-1.
  - Outputs are registered, so element 0 is valid one cycle after FRAME_READY was sampled.
  - Per element: W_EN=1, W_ROW=i/IMG_COLS, W_COL=i%IMG_COLS.
  - Per element: W_DATA={8'b0, byte_i, 2'b0}, i.e. unsigned byte times 4, 2 fractional bits, always non-negative.
  - Row/col are produced by incrementing counters (col wraps 27->0 and increments row); no divider.
- End of frame:
  - Leaving the last element (i=783, row 27 col 27), the next cycle has W_EN=0, W_DONE=1 for exactly one cycle, W_ROW=0, W_COL=0.
  - Then the block returns to IDLE.
- SRC_*_NN hold their latched values until the next accepted FRAME_READY; they are unaffected by end of frame.
- FRAME_READY during STREAM is ignored: no restart, and the buffer and addresses are unchanged.
- FRAME_READY on the W_DONE cycle is accepted (block is IDLE-equivalent).
- Input changes on DATA_FRAME_IP after capture do not affect the stream.
- Reset mid-stream aborts immediately: W_EN=0, no W_DONE.

Optional Feature:
- Macro BUFF_DONE_STICKY_EN.
- Defined: W_DONE is set at end of frame and stays 1 until the next accepted FRAME_READY (cleared on that capture edge) or reset.
- Undefined: W_DONE is a one-cycle pulse as above.

Test Plan:
- Reset: ARESET=1 with frames pending -> W_EN=0, W_DONE=0, W_ROW=W_COL=0, W_DATA=0, SRC_*_NN=0.
- Frame A:
  - Stimulus: MAC 48'hdeadbeefb00b, IP 32'h01020304, port 666, byte i = i%27, one-cycle FRAME_READY.
  - Response: from the next cycle, 784 consecutive cycles with W_EN=1, row=i/28, col=i%28, W_DATA=(i%27)<<2.
  - Next cycle: W_EN=0, W_DONE=1, row=col=0, SRC_*_NN equal to the inputs.
- Frame B 20 ns later:
  - Stimulus: MAC 48'hbed1becc1122, IP 32'h05060708, port 999.
  - Response: identical stream checks; addresses updated to the new values.
- FRAME_READY pulsed at i=100 mid-stream with different data -> stream continues unchanged; total 784 writes and one W_DONE.
- ARESET asserted at i=400 -> W_EN drops asynchronously, no W_DONE; a new FRAME_READY after release streams from row 0 col 0.
- Byte 8'hFF at i=0 -> W_DATA=18'h003FC (positive 1020); byte 0 -> 0.

Source files
------------

// File: rtl/buff_ip_to_nn_if.sv
// buff_ip_to_nn_if: frame-in / NN-write-out signal bundle for buff_ip_to_nn.
//   master: IP-side source, drives frame, SRC_*_IP and FRAME_READY; observes NN side.
//   slave : the bridge, receives frame, drives SRC_*_NN and W_DATA/W_EN/W_ROW/W_COL/W_DONE.
interface buff_ip_to_nn_if #(
  parameter int USER_DATA_BYTES = 784,
  parameter int IP_ADDR_WIDTH = 32,
  parameter int MAC_ADDR_WIDTH = 48,
  parameter int UDP_PORT_WIDTH = 16
);
  logic [0:USER_DATA_BYTES*8-1] DATA_FRAME_IP;
  logic [0:IP_ADDR_WIDTH-1] SRC_IP_ADDRESS_IP;
  logic [0:MAC_ADDR_WIDTH-1] SRC_MAC_ADDRESS_IP;
  logic [0:UDP_PORT_WIDTH-1] SRC_UDP_PORT_IP;
  logic FRAME_READY;
  logic [0:IP_ADDR_WIDTH-1] SRC_IP_ADDRESS_NN;
  logic [0:MAC_ADDR_WIDTH-1] SRC_MAC_ADDRESS_NN;
  logic [0:UDP_PORT_WIDTH-1] SRC_UDP_PORT_NN;
  logic signed [17:0] W_DATA;
  logic W_EN;
  logic [4:0] W_ROW;
  logic [4:0] W_COL;
  logic W_DONE;
  modport master (
    output DATA_FRAME_IP, SRC_IP_ADDRESS_IP, SRC_MAC_ADDRESS_IP, SRC_UDP_PORT_IP, FRAME_READY,
    input SRC_IP_ADDRESS_NN, SRC_MAC_ADDRESS_NN, SRC_UDP_PORT_NN, W_DATA, W_EN, W_ROW, W_COL, W_DONE
  );
  modport slave (
    input DATA_FRAME_IP, SRC_IP_ADDRESS_IP, SRC_MAC_ADDRESS_IP, SRC_UDP_PORT_IP, FRAME_READY,
    output SRC_IP_ADDRESS_NN, SRC_MAC_ADDRESS_NN, SRC_UDP_PORT_NN, W_DATA, W_EN, W_ROW, W_COL, W_DONE
  );
endinterface

// File: rtl/buff_ip_to_nn.sv
// buff_ip_to_nn: latches a UDP frame + sender addressing and streams it pixel-by-pixel into NN image memory.
//   ACLK/ARESET : clock, async active-high reset
//   bus (slave) : frame/address inputs with FRAME_READY strobe; registered SRC_*_NN and W_* write outputs
//   BUFF_DONE_STICKY_EN : when defined, W_DONE holds until the next accepted frame instead of pulsing
module buff_ip_to_nn #(
  parameter int USER_DATA_BYTES = 784,
  parameter int IMG_COLS = 28,
  parameter int IP_ADDR_WIDTH = 32,
  parameter int MAC_ADDR_WIDTH = 48,
  parameter int UDP_PORT_WIDTH = 16
) (
  input logic ACLK,
  input logic ARESET,
  buff_ip_to_nn_if.slave bus
);
  localparam int IW = $clog2(USER_DATA_BYTES + 1);
  localparam logic [4:0] COL_LAST = 5'(IMG_COLS - 1);
  typedef enum logic {IDLE, STREAM} state_t;
  state_t state;
  logic [0:USER_DATA_BYTES*8-1] frame;
  logic [IW-1:0] idx;
  logic done;
  assign done = idx == IW'(USER_DATA_BYTES);
  always_ff @(posedge ACLK or posedge ARESET)
    if (ARESET) begin
      state <= IDLE;
      frame <= '0;
      idx <= '0;
      bus.SRC_IP_ADDRESS_NN <= '0;
      bus.SRC_MAC_ADDRESS_NN <= '0;
      bus.SRC_UDP_PORT_NN <= '0;
      bus.W_DATA <= '0;
      bus.W_EN <= 1'b0;
      bus.W_ROW <= '0;
      bus.W_COL <= '0;
      bus.W_DONE <= 1'b0;
    end else if (state == IDLE) begin
      bus.W_EN <= 1'b0;
      bus.W_ROW <= '0;
      bus.W_COL <= '0;
`ifndef BUFF_DONE_STICKY_EN
      bus.W_DONE <= 1'b0;
`endif
      if (bus.FRAME_READY) begin
        frame <= bus.DATA_FRAME_IP;
        bus.SRC_IP_ADDRESS_NN <= bus.SRC_IP_ADDRESS_IP;
        bus.SRC_MAC_ADDRESS_NN <= bus.SRC_MAC_ADDRESS_IP;
        bus.SRC_UDP_PORT_NN <= bus.SRC_UDP_PORT_IP;
        bus.W_DONE <= 1'b0;
        idx <= '0;
        state <= STREAM;
      end
    end else if (done) begin
      bus.W_EN <= 1'b0;
      bus.W_DONE <= 1'b1;
      bus.W_ROW <= '0;
      bus.W_COL <= '0;
      state <= IDLE;
    end else begin
      // W_EN low means this is the first element, so row/col restart at 0
      bus.W_EN <= 1'b1;
      bus.W_DATA <= {8'b0, frame[{idx, 3'b0} +: 8], 2'b0};
      bus.W_COL <= (!bus.W_EN || bus.W_COL == COL_LAST) ? '0 : bus.W_COL + 5'd1;
      bus.W_ROW <= !bus.W_EN ? '0 : bus.W_ROW + 5'(bus.W_COL == COL_LAST);
      idx <= idx + IW'(1);
    end
endmodule

// File: tb/tb_buff_ip_to_nn.sv
// tb_buff_ip_to_nn: randomized self-checking bench for buff_ip_to_nn against a byte-array reference model.
module tb_buff_ip_to_nn;
  localparam int N = 784;
  localparam int COLS = 28;
  logic clk = 1'b0;
  logic rst;
  int n_chk = 0;
  int n_pass = 0;
  logic [7:0] px [N];
  logic [7:0] junk [N];
  buff_ip_to_nn_if bus ();
  buff_ip_to_nn dut (.ACLK(clk), .ARESET(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  function automatic logic [0:N*8-1] pack(input logic [7:0] p [N]);
    logic [0:N*8-1] v;
    for (int i = 0; i < N; i++) v[i*8 +: 8] = p[i];
    return v;
  endfunction
  task automatic send(input logic [47:0] mac, input logic [31:0] ip, input logic [15:0] port);
    bus.DATA_FRAME_IP = pack(px);
    bus.SRC_MAC_ADDRESS_IP = mac;
    bus.SRC_IP_ADDRESS_IP = ip;
    bus.SRC_UDP_PORT_IP = port;
    bus.FRAME_READY = 1'b1;
    @(negedge clk);
    bus.FRAME_READY = 1'b0;
    bus.DATA_FRAME_IP = ~pack(px);
  endtask
  task automatic check_addr(input string tag, input logic [47:0] mac, input logic [31:0] ip, input logic [15:0] port);
    chk({tag, "_mac"}, 64'(bus.SRC_MAC_ADDRESS_NN), 64'(mac));
    chk({tag, "_ip"}, 64'(bus.SRC_IP_ADDRESS_NN), 64'(ip));
    chk({tag, "_port"}, 64'(bus.SRC_UDP_PORT_NN), 64'(port));
  endtask
  task automatic run_stream(input logic [47:0] mac, input logic [31:0] ip, input logic [15:0] port,
                            input int glitch_at, input int rst_at);
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      chk("w_en", 64'(bus.W_EN), 64'd1);
      chk("w_done_low", 64'(bus.W_DONE), 64'd0);
      chk("w_row", 64'(bus.W_ROW), 64'(i / COLS));
      chk("w_col", 64'(bus.W_COL), 64'(i % COLS));
      chk("w_data", 64'($unsigned(bus.W_DATA)), 64'(px[i]) * 4);
      if (i == glitch_at) begin
        for (int k = 0; k < N; k++) junk[k] = 8'($urandom_range(0, 255));
        bus.DATA_FRAME_IP = pack(junk);
        bus.SRC_MAC_ADDRESS_IP = ~mac;
        bus.SRC_IP_ADDRESS_IP = ~ip;
        bus.SRC_UDP_PORT_IP = ~port;
        bus.FRAME_READY = 1'b1;
      end
      if (i == glitch_at + 1) bus.FRAME_READY = 1'b0;
      if (i == rst_at) begin
        rst = 1'b1;
        #1;
        chk("abort_w_en", 64'(bus.W_EN), 64'd0);
        chk("abort_w_done", 64'(bus.W_DONE), 64'd0);
        check_addr("abort", 48'd0, 32'd0, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("post_abort_w_en", 64'(bus.W_EN), 64'd0);
          chk("post_abort_w_done", 64'(bus.W_DONE), 64'd0);
        end
        return;
      end
    end
    @(negedge clk);
    chk("end_w_en", 64'(bus.W_EN), 64'd0);
    chk("end_w_done", 64'(bus.W_DONE), 64'd1);
    chk("end_row", 64'(bus.W_ROW), 64'd0);
    chk("end_col", 64'(bus.W_COL), 64'd0);
    check_addr("end", mac, ip, port);
  endtask
  task automatic after_done(input logic [47:0] mac, input logic [31:0] ip, input logic [15:0] port);
    @(negedge clk);
    chk("idle_w_en", 64'(bus.W_EN), 64'd0);
`ifdef BUFF_DONE_STICKY_EN
    chk("idle_w_done", 64'(bus.W_DONE), 64'd1);
`else
    chk("idle_w_done", 64'(bus.W_DONE), 64'd0);
`endif
    check_addr("idle", mac, ip, port);
  endtask
  task automatic rand_frame();
    for (int i = 0; i < N; i++) px[i] = 8'($urandom_range(0, 255));
  endtask
  initial begin
    logic [47:0] mac;
    logic [31:0] ip;
    logic [15:0] port;
    rst = 1'b1;
    rand_frame();
    bus.DATA_FRAME_IP = pack(px);
    bus.SRC_MAC_ADDRESS_IP = 48'h123456789abc;
    bus.SRC_IP_ADDRESS_IP = 32'hc0a80001;
    bus.SRC_UDP_PORT_IP = 16'd1234;
    bus.FRAME_READY = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_w_en", 64'(bus.W_EN), 64'd0);
    chk("rst_w_done", 64'(bus.W_DONE), 64'd0);
    chk("rst_row", 64'(bus.W_ROW), 64'd0);
    chk("rst_col", 64'(bus.W_COL), 64'd0);
    chk("rst_data", 64'($unsigned(bus.W_DATA)), 64'd0);
    check_addr("rst", 48'd0, 32'd0, 16'd0);
    bus.FRAME_READY = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    // frame A
    for (int i = 0; i < N; i++) px[i] = 8'(i % 27);
    send(48'hdeadbeefb00b, 32'h01020304, 16'd666);
    run_stream(48'hdeadbeefb00b, 32'h01020304, 16'd666, -10, -1);
    after_done(48'hdeadbeefb00b, 32'h01020304, 16'd666);
    @(negedge clk);
    // frame B, boundary bytes at the start
    rand_frame();
    px[0] = 8'hff;
    px[1] = 8'h00;
    send(48'hbed1becc1122, 32'h05060708, 16'd999);
    run_stream(48'hbed1becc1122, 32'h05060708, 16'd999, -10, -1);
    after_done(48'hbed1becc1122, 32'h05060708, 16'd999);
    // frame C with a FRAME_READY glitch mid-stream
    rand_frame();
    mac = {$urandom, $urandom} & 48'hffffffffffff;
    ip = $urandom;
    port = 16'($urandom);
    send(mac, ip, port);
    run_stream(mac, ip, port, 100, -1);
    after_done(mac, ip, port);
    // frame D aborted by reset
    rand_frame();
    send(48'h0a0b0c0d0e0f, 32'h0a000001, 16'd4242);
    run_stream(48'h0a0b0c0d0e0f, 32'h0a000001, 16'd4242, -10, 400);
    // frame E after the abort, then frame F accepted on the W_DONE cycle
    rand_frame();
    mac = {$urandom, $urandom} & 48'hffffffffffff;
    ip = $urandom;
    port = 16'($urandom);
    send(mac, ip, port);
    run_stream(mac, ip, port, -10, -1);
    rand_frame();
    px[N-1] = 8'hff;
    mac = ~mac;
    ip = ~ip;
    port = ~port;
    send(mac, ip, port);
    run_stream(mac, ip, port, -10, -1);
    after_done(mac, ip, port);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
